// File: rtl/sap1_controlador.sv
// SAP-1 controller-sequencer: six-state ring counter (T1..T6) with HALT, advanced on the
// falling clock edge, plus a combinational decode of state and opcode into the control word.
module sap1_controlador (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [3:0] opcode,
    output logic       cp,
    output logic       ep,
    output logic       n_lm,
    output logic       n_ce,
    output logic       n_li,
    output logic       n_ei,
    output logic       n_la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       n_lb,
    output logic       n_lo,
    output logic       halt,
    output logic [5:0] t_state
);
    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        S_T1   = 3'd0,
        S_T2   = 3'd1,
        S_T3   = 3'd2,
        S_T4   = 3'd3,
        S_T5   = 3'd4,
        S_T6   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_arith;

    // State changes on the falling edge so the control word settles before the datapath's rising edge
    always_ff @(negedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_T1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_T1:    w_next = S_T2;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = S_T4;
            S_T4:    w_next = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    w_next = S_T6;
            S_T6:    w_next = S_T1;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_T1;
        endcase
    end

    assign w_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

    // Control word decode; held inactive while reset is asserted
    always_comb begin
        cp      = 1'b0;
        ep      = 1'b0;
        n_lm    = 1'b1;
        n_ce    = 1'b1;
        n_li    = 1'b1;
        n_ei    = 1'b1;
        n_la    = 1'b1;
        ea      = 1'b0;
        su      = 1'b0;
        eu      = 1'b0;
        n_lb    = 1'b1;
        n_lo    = 1'b1;
        halt    = 1'b0;
        t_state = 6'b000000;
        if (!n_rst) begin
            t_state = 6'b000001;
        end else begin
            case (r_state)
                S_T1: begin
                    t_state = 6'b000001;
                    ep      = 1'b1;
                    n_lm    = 1'b0;
                end
                S_T2: begin
                    t_state = 6'b000010;
                    cp      = 1'b1;
                end
                S_T3: begin
                    t_state = 6'b000100;
                    n_ce    = 1'b0;
                    n_li    = 1'b0;
                end
                S_T4: begin
                    t_state = 6'b001000;
                    if ((opcode == OP_LDA) || w_arith) begin
                        n_ei = 1'b0;
                        n_lm = 1'b0;
                    end else if (opcode == OP_OUT) begin
                        ea   = 1'b1;
                        n_lo = 1'b0;
                    end
                end
                S_T5: begin
                    t_state = 6'b010000;
                    if (opcode == OP_LDA) begin
                        n_ce = 1'b0;
                        n_la = 1'b0;
                    end else if (w_arith) begin
                        n_ce = 1'b0;
                        n_lb = 1'b0;
                    end
                end
                S_T6: begin
                    t_state = 6'b100000;
                    if (w_arith) begin
                        eu   = 1'b1;
                        n_la = 1'b0;
                        su   = (opcode == OP_SUB);
                    end
                end
                S_HALT: begin
                    halt = 1'b1;
                end
                default: begin
                    t_state = 6'b000000;
                end
            endcase
        end
    end

endmodule
